// File: rtl/sr_median_decide.sv
// Median-based impulse-noise decision at the tail of the DBSNR sorting chain.
// Replaces a noisy centre pixel with the window median or the last emitted pixel.
module sr_median_decide #(
  parameter int W        = 10,
  parameter int N        = 9,
  parameter int NOISE_LO = 0,
  parameter int NOISE_HI = 1023
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] sorted,
  input  logic [W-1:0]   center,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_pix,
  output logic           out_noisy,
  output logic           window_full,
  output logic [15:0]    noisy_cnt,
  output logic           drop_err
);

  localparam int             MEDI     = (N - 1) / 2;
  localparam int             FW       = $clog2(N + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(N);
  localparam logic [W-1:0]   MID      = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]   LO       = W'(NOISE_LO);
  localparam logic [W-1:0]   HI       = W'(NOISE_HI);

  typedef struct packed {
    logic [W-1:0] pix;
    logic         noisy;
  } res_t;

  logic [FW-1:0] fill_cnt, fill_base, fill_nxt;
  logic [W-1:0]  prev_pix, prev_base, med;
  logic [15:0]   cnt_base, cnt_nxt;
  logic          accept, warm, center_clean, med_clean;
  res_t          dec;

  // Only the median entry drives the decision; the rest of the chain is ignored.
  logic unused_entries;
  assign unused_entries = ^{sorted[N*W-1:(MEDI+1)*W], sorted[MEDI*W-1:0]};

  always_comb begin
    in_ready     = !out_valid || out_ready;
    accept       = in_valid && in_ready;
    // A flush in the accept cycle makes this sample the first of a new frame.
    fill_base    = flush ? '0  : fill_cnt;
    prev_base    = flush ? MID : prev_pix;
    cnt_base     = flush ? '0  : noisy_cnt;
    med          = sorted[MEDI*W +: W];
    warm         = (fill_base != FILL_MAX);
    center_clean = (center > LO) && (center < HI);
    med_clean    = (med > LO) && (med < HI);
    dec          = '{pix: center, noisy: 1'b0};
    if (!warm && !center_clean) begin
      dec.noisy = 1'b1;
      dec.pix   = med_clean ? med : prev_base;
    end
    fill_nxt = (fill_base == FILL_MAX) ? FILL_MAX : fill_base + FW'(1);
    cnt_nxt  = cnt_base;
    if (accept && dec.noisy && (cnt_base != 16'hFFFF))
      cnt_nxt = cnt_base + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_pix     <= '0;
      out_noisy   <= 1'b0;
      window_full <= 1'b0;
      noisy_cnt   <= '0;
      drop_err    <= 1'b0;
      fill_cnt    <= '0;
      prev_pix    <= MID;
    end else begin
      if (accept) begin
        out_valid   <= 1'b1;
        out_pix     <= dec.pix;
        out_noisy   <= dec.noisy;
        prev_pix    <= dec.pix;
        fill_cnt    <= fill_nxt;
        window_full <= (fill_nxt == FILL_MAX);
      end else begin
        if (out_ready)
          out_valid <= 1'b0;
        if (flush) begin
          prev_pix    <= MID;
          fill_cnt    <= '0;
          window_full <= 1'b0;
        end
      end
      noisy_cnt <= cnt_nxt;
      if (in_valid && !in_ready)
        drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_median_decide.sv
// Directed plus randomized bench for sr_median_decide with a frame-level reference model.
module tb_sr_median_decide;

  localparam int W    = 10;
  localparam int N    = 9;
  localparam int MEDI = (N - 1) / 2;
  localparam int LO   = 0;
  localparam int HI   = 1023;

  logic           clk, reset;
  logic           in_valid, in_ready, flush, out_valid, out_ready;
  logic [N*W-1:0] sorted;
  logic [W-1:0]   center, out_pix;
  logic           out_noisy, window_full, drop_err;
  logic [15:0]    noisy_cnt;

  sr_median_decide #(.W(W), .N(N), .NOISE_LO(LO), .NOISE_HI(HI)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sorted(sorted), .center(center), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pix(out_pix), .out_noisy(out_noisy),
    .window_full(window_full), .noisy_cnt(noisy_cnt), .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int   m_fill, m_noisy, m_prev, m_pix;
  bit   m_nz, m_ov, m_drop;
  int   win_med;
  logic [N*W-1:0] win_bus;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit is_clean(input int x);
    return (x > LO) && (x < HI);
  endfunction

  function automatic int rand_pix();
    case ($urandom_range(0, 4))
      0:       return LO;
      1:       return HI;
      default: return int'($urandom_range(0, (1 << W) - 1));
    endcase
  endfunction

  task automatic model_reset();
    m_fill = 0; m_noisy = 0; m_prev = 1 << (W - 1);
    m_pix = 0; m_nz = 0; m_ov = 0; m_drop = 0;
  endtask

  // Builds an ascending window from arbitrary values; median comes from the sorted list.
  task automatic make_win(input int v[N]);
    int q[$];
    q = {};
    for (int i = 0; i < N; i++) q.push_back(v[i]);
    q.sort();
    for (int i = 0; i < N; i++) win_bus[i*W +: W] = W'(q[i]);
    win_med = q[MEDI];
  endtask

  task automatic rand_win();
    int v[N];
    for (int i = 0; i < N; i++) v[i] = rand_pix();
    make_win(v);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_ov);
    if (m_ov) begin
      chk({tag, ".out_pix"}, out_pix, m_pix);
      chk({tag, ".out_noisy"}, out_noisy, m_nz);
    end
    chk({tag, ".window_full"}, window_full, (m_fill == N));
    chk({tag, ".noisy_cnt"}, noisy_cnt, m_noisy);
    chk({tag, ".drop_err"}, drop_err, m_drop);
  endtask

  // One clock of stimulus: drive, check ready, advance the model, clock, check outputs.
  task automatic step(input string tag, input bit iv, input bit fl, input bit ordy, input int c);
    bit rdy, acc;
    in_valid = iv; flush = fl; out_ready = ordy;
    center = W'(c); sorted = win_bus;
    #1;
    rdy = !m_ov || ordy;
    acc = iv && rdy;
    chk({tag, ".in_ready"}, in_ready, rdy);
    if (iv && !rdy) m_drop = 1;
    if (fl) begin m_fill = 0; m_prev = 1 << (W - 1); m_noisy = 0; end
    if (acc) begin
      if (m_fill < N || is_clean(c)) begin m_pix = c; m_nz = 0; end
      else if (is_clean(win_med)) begin m_pix = win_med; m_nz = 1; end
      else begin m_pix = m_prev; m_nz = 1; end
      m_prev = m_pix;
      if (m_fill < N) m_fill++;
      if (m_nz && m_noisy < 65535) m_noisy++;
      m_ov = 1;
    end else if (ordy) m_ov = 0;
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  initial begin
    int v[N];
    reset = 1'b0;
    in_valid = 0; flush = 0; out_ready = 0; center = '0; sorted = '0; win_bus = '0;
    model_reset();

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); flush = 1'($urandom); out_ready = 1'($urandom);
      center = W'($urandom); sorted = {N{W'($urandom)}};
    end
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_pix", out_pix, 0);
    chk("rst.out_noisy", out_noisy, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.window_full", window_full, 0);
    chk("rst.noisy_cnt", noisy_cnt, 0);
    chk("rst.drop_err", drop_err, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // warm-up: first N accepts pass the centre through
    for (int i = 0; i < N; i++) begin
      rand_win();
      step("warm", 1, 0, 1, 300);
      chk("warm.pix300", out_pix, 300);
    end
    chk("warm.full", window_full, 1);

    // noisy centre, clean median
    v = '{0, 0, 100, 200, 250, 300, 400, 1023, 1023};
    make_win(v);
    step("med", 1, 0, 1, 1023);
    chk("med.pix250", out_pix, 250);
    chk("med.cnt1", noisy_cnt, 1);

    // noisy centre, noisy median -> previous output
    v = '{0, 0, 0, 0, 0, 5, 6, 7, 1023};
    make_win(v);
    step("prev", 1, 0, 1, 0);
    chk("prev.pix250", out_pix, 250);
    chk("prev.cnt2", noisy_cnt, 2);

    // backpressure with a dropped sample
    rand_win();
    step("stall0", 0, 0, 0, 0);
    step("stall1", 0, 0, 0, 0);
    step("stall2", 1, 0, 0, 777);
    chk("stall.hold_pix", out_pix, 250);
    chk("stall.drop", drop_err, 1);
    step("resume0", 1, 0, 1, 400);
    step("resume1", 1, 0, 1, 1023);
    step("resume2", 0, 0, 1, 0);

    // flush coinciding with accept starts a new frame
    rand_win();
    step("flushacc", 1, 1, 1, 1023);
    chk("flushacc.pix", out_pix, 1023);
    chk("flushacc.noisy", out_noisy, 0);

    // reset mid-stream drops out_valid without a clock edge
    step("prerst", 1, 0, 0, 600);
    reset = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_win();
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) != 0, rand_pix());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
